cfg_axil_master: RTL and testbench
==================================

Name: cfg_axil_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns simple register requests into AW/W/B or AR/R transactions.
- Drives the cfg_* slave port of peripheral blocks (IRQ controller, timers, UART) from the SoC debug/boot sequencer or a CPU-side bridge.
- Returns one response pulse per request, carrying read data and the response code.

Parameters:
- ADDR_W, 32, width of request and AXI address.
- TIMEOUT_CYCLES, 256, watchdog limit in clk_i cycles per transaction (used only with CFG_AXIL_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  byte strobes
- resp_valid_o  out  1  one-cycle response pulse
- resp_rdata_o  out  32  read data, 0 for writes
- resp_code_o  out  2  BRESP/RRESP; 2'b11 = timeout
- cfg_awvalid_o/cfg_awaddr_o[ADDR_W]  out  write address channel
- cfg_awready_i  in  1
- cfg_wvalid_o/cfg_wdata_o[32]/cfg_wstrb_o[4]  out  write data channel
- cfg_wready_i  in  1
- cfg_bvalid_i  in  1;  cfg_bresp_i  in  2;  cfg_bready_o  out  1
- cfg_arvalid_o/cfg_araddr_o[ADDR_W]  out  read address channel
- cfg_arready_i  in  1
- cfg_rvalid_i  in  1;  cfg_rdata_i  in  32;  cfg_rresp_i  in  2;  cfg_rready_o  out  1

Behaviour:
- Single clock domain. Reset is synchronous, active-high on rst_i.
- Reset values: all *valid_o, cfg_bready_o, cfg_rready_o, and resp_valid_o are 0. Addresses, data, strb, resp_rdata_o, and resp_code_o are 0. FSM is in IDLE.
- req_ready_o = 1 only in IDLE; it is a registered state decode.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE, on req_valid_i:
  - Capture addr, wdata, and wstrb into registers.
  - Write: go to WR_REQ with cfg_awvalid_o=cfg_wvalid_o=1 in the same next cycle.
  - Read: go to RD_REQ with cfg_arvalid_o=1.
- WR_REQ:
  - AW and W are raised together. Each valid drops on the cycle after its own handshake (valid&ready sampled at the clock edge).
  - Either handshake may come first or both in the same cycle. Track with aw_done and w_done flags.
  - When both are done, go to WR_RESP with cfg_bready_o=1.
  - Valids never drop before their handshake (except on timeout).
- WR_RESP: on cfg_bvalid_i&cfg_bready_o:
  - Register resp_code_o=cfg_bresp_i, resp_rdata_o=0, resp_valid_o=1 for exactly one cycle.
  - Clear bready and return to IDLE.
  - A B response arriving in the same cycle as the last AW/W handshake is not consumed; bready is only asserted in WR_RESP.
- RD_REQ: on cfg_arready_i, drop arvalid and go to RD_RESP with cfg_rready_o=1.
- RD_RESP: on cfg_rvalid_i&cfg_rready_o:
  - Register resp_rdata_o=cfg_rdata_i, resp_code_o=cfg_rresp_i, resp_valid_o=1 for one cycle.
  - Return to IDLE.
- Never more than one transaction outstanding. arvalid and awvalid are never high together.
- Request-to-response minimum latency:
  - Write: 4 cycles (accept, AW/W handshake, B handshake, resp pulse) with zero-wait slave.
  - Read: 4 cycles.
- resp_valid_o has no backpressure. The requester must sample it.
- A new request is accepted on the cycle resp_valid_o is high (back-to-back allowed, since state is IDLE).
- Reset mid-transaction:
  - All outputs return to reset values next edge. The outstanding transaction is abandoned and no response pulse is issued.
  - The slave is expected to be reset by the same rst_i.
- AXI prot/burst signals are not provided. The slave treats each access as a single 32-bit beat.

Optional Feature:
- Macro CFG_AXIL_TIMEOUT_EN.
- Defined:
  - A counter clears on leaving IDLE and increments every cycle in a non-IDLE state.
  - When it reaches TIMEOUT_CYCLES-1 without completing, the FSM forces all valids/readys to 0 and returns to IDLE.
  - It emits resp_valid_o=1, resp_code_o=2'b11, resp_rdata_o=32'hDEAD_BEEF.
  - Completion in the same cycle as expiry counts as normal completion.
- Undefined: no counter logic. The FSM waits indefinitely. Code 2'b11 is only ever a passthrough of a slave response.

Test Plan:
- Write 0x0000_0008 data 0x0000_000F strb 4'hF, zero-wait slave -> AW and W valid in the same cycle; one B handshake; resp_valid_o one cycle, resp_code_o=2'b00, 4-cycle latency.
- Read 0x0000_0010 with slave returning rdata 0x0000_0002 after 3 wait cycles on R -> resp_rdata_o=0x0000_0002, resp_code_o=2'b00, rready held high through waits.
- Write where wready arrives 2 cycles before awready -> wvalid drops after the W handshake, awvalid stays high until the AW handshake, exactly one response.
- Back-to-back: write then read presented continuously -> second request accepted on the resp_valid_o cycle of the first; arvalid never overlaps awvalid.
- Slave returns bresp=2'b10 -> resp_code_o=2'b10; rst_i asserted in RD_RESP -> outputs zero next cycle, no resp pulse.
- CFG_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready tied 0 -> after 16 cycles arvalid drops, resp_code_o=2'b11, resp_rdata_o=0xDEADBEEF.

Source files
------------

// File: rtl/cfg_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one register request in, one AW/W/B or AR/R transaction out, one response pulse back.
// Optional watchdog: define CFG_AXIL_TIMEOUT_EN to abort stuck transactions after TIMEOUT_CYCLES with code 2'b11.
module cfg_axil_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_wstrb_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic [1:0]        resp_code_o,
  output logic              cfg_awvalid_o,
  output logic [ADDR_W-1:0] cfg_awaddr_o,
  input  logic              cfg_awready_i,
  output logic              cfg_wvalid_o,
  output logic [31:0]       cfg_wdata_o,
  output logic [3:0]        cfg_wstrb_o,
  input  logic              cfg_wready_i,
  input  logic              cfg_bvalid_i,
  input  logic [1:0]        cfg_bresp_i,
  output logic              cfg_bready_o,
  output logic              cfg_arvalid_o,
  output logic [ADDR_W-1:0] cfg_araddr_o,
  input  logic              cfg_arready_i,
  input  logic              cfg_rvalid_i,
  input  logic [31:0]       cfg_rdata_i,
  input  logic [1:0]        cfg_rresp_i,
  output logic              cfg_rready_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CODE_W = 2;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_req_ready, w_req_ready_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
  logic                r_awvalid, w_awvalid_nxt;
  logic                r_wvalid, w_wvalid_nxt;
  logic                r_aw_done, w_aw_done_nxt;
  logic                r_w_done, w_w_done_nxt;
  logic                r_bready, w_bready_nxt;
  logic                r_arvalid, w_arvalid_nxt;
  logic                r_rready, w_rready_nxt;
  logic                r_resp_valid, w_resp_valid_nxt;
  logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata_nxt;
  logic [CODE_W-1:0]   r_resp_code, w_resp_code_nxt;

  logic w_accept, w_aw_hs, w_w_hs, w_aw_done, w_w_done, w_b_hs, w_ar_hs, w_r_hs;
  logic w_timeout;

  assign w_accept  = r_req_ready & req_valid_i;
  assign w_aw_hs   = r_awvalid & cfg_awready_i;
  assign w_w_hs    = r_wvalid & cfg_wready_i;
  assign w_aw_done = r_aw_done | w_aw_hs;
  assign w_w_done  = r_w_done | w_w_hs;
  assign w_b_hs    = r_bready & cfg_bvalid_i;
  assign w_ar_hs   = r_arvalid & cfg_arready_i;
  assign w_r_hs    = r_rready & cfg_rvalid_i;

`ifdef CFG_AXIL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] r_tmo_cnt;

  // Per-transaction age; a completing handshake on the expiry cycle wins.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == S_IDLE) r_tmo_cnt <= '0;
    else                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  assign w_timeout = (r_state != S_IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))
                     && !(w_b_hs || w_r_hs);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = req_we_i ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:  if (w_aw_done && w_w_done) w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (w_b_hs) w_state_nxt = S_IDLE;
      S_RD_REQ:  if (w_ar_hs) w_state_nxt = S_RD_RESP;
      S_RD_RESP: if (w_r_hs) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  // Next values of the registered outputs
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == S_IDLE);
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_awvalid_nxt    = 1'b0;
    w_wvalid_nxt     = 1'b0;
    w_aw_done_nxt    = r_aw_done;
    w_w_done_nxt     = r_w_done;
    w_bready_nxt     = 1'b0;
    w_arvalid_nxt    = 1'b0;
    w_rready_nxt     = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_code_nxt  = r_resp_code;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nxt    = req_addr_i;
          w_wdata_nxt   = req_wdata_i;
          w_wstrb_nxt   = req_wstrb_i;
          w_awvalid_nxt = req_we_i;
          w_wvalid_nxt  = req_we_i;
          w_arvalid_nxt = ~req_we_i;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      S_WR_REQ: begin
        w_awvalid_nxt = r_awvalid & ~w_aw_hs;
        w_wvalid_nxt  = r_wvalid & ~w_w_hs;
        w_aw_done_nxt = w_aw_done;
        w_w_done_nxt  = w_w_done;
        w_bready_nxt  = w_aw_done & w_w_done;
      end
      S_WR_RESP: begin
        w_bready_nxt = ~w_b_hs;
        if (w_b_hs) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = '0;
          w_resp_code_nxt  = cfg_bresp_i;
        end
      end
      S_RD_REQ: begin
        w_arvalid_nxt = ~w_ar_hs;
        w_rready_nxt  = w_ar_hs;
      end
      S_RD_RESP: begin
        w_rready_nxt = ~w_r_hs;
        if (w_r_hs) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = cfg_rdata_i;
          w_resp_code_nxt  = cfg_rresp_i;
        end
      end
      default: ;
    endcase
`ifdef CFG_AXIL_TIMEOUT_EN
    if (w_timeout) begin
      w_awvalid_nxt    = 1'b0;
      w_wvalid_nxt     = 1'b0;
      w_bready_nxt     = 1'b0;
      w_arvalid_nxt    = 1'b0;
      w_rready_nxt     = 1'b0;
      w_resp_valid_nxt = 1'b1;
      w_resp_rdata_nxt = 32'hDEAD_BEEF;
      w_resp_code_nxt  = 2'b11;
    end
`endif
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_ready  <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_code  <= '0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_aw_done    <= w_aw_done_nxt;
      r_w_done     <= w_w_done_nxt;
      r_bready     <= w_bready_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_code  <= w_resp_code_nxt;
    end
  end

  assign req_ready_o   = r_req_ready;
  assign resp_valid_o  = r_resp_valid;
  assign resp_rdata_o  = r_resp_rdata;
  assign resp_code_o   = r_resp_code;
  assign cfg_awvalid_o = r_awvalid;
  assign cfg_awaddr_o  = r_addr;
  assign cfg_wvalid_o  = r_wvalid;
  assign cfg_wdata_o   = r_wdata;
  assign cfg_wstrb_o   = r_wstrb;
  assign cfg_bready_o  = r_bready;
  assign cfg_arvalid_o = r_arvalid;
  assign cfg_araddr_o  = r_addr;
  assign cfg_rready_o  = r_rready;

endmodule

// File: tb/tb_cfg_axil_master.sv
// Directed self-checking bench for cfg_axil_master; the TB plays the AXI4-Lite slave cycle by cycle.
// Inputs change and outputs are sampled at the falling edge.
module tb_cfg_axil_master;

  localparam int unsigned ADDR_W = 32;
`ifdef CFG_AXIL_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 256;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i, req_ready_o, req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [3:0]        req_wstrb_i;
  logic              resp_valid_o;
  logic [31:0]       resp_rdata_o;
  logic [1:0]        resp_code_o;
  logic              cfg_awvalid_o, cfg_awready_i;
  logic [ADDR_W-1:0] cfg_awaddr_o;
  logic              cfg_wvalid_o, cfg_wready_i;
  logic [31:0]       cfg_wdata_o;
  logic [3:0]        cfg_wstrb_o;
  logic              cfg_bvalid_i, cfg_bready_o;
  logic [1:0]        cfg_bresp_i;
  logic              cfg_arvalid_o, cfg_arready_i;
  logic [ADDR_W-1:0] cfg_araddr_o;
  logic              cfg_rvalid_i, cfg_rready_o;
  logic [31:0]       cfg_rdata_i;
  logic [1:0]        cfg_rresp_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_overlap = 0;

  always #5 clk_i = ~clk_i;

  cfg_axil_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_code_o(resp_code_o),
    .cfg_awvalid_o(cfg_awvalid_o), .cfg_awaddr_o(cfg_awaddr_o), .cfg_awready_i(cfg_awready_i),
    .cfg_wvalid_o(cfg_wvalid_o), .cfg_wdata_o(cfg_wdata_o), .cfg_wstrb_o(cfg_wstrb_o),
    .cfg_wready_i(cfg_wready_i),
    .cfg_bvalid_i(cfg_bvalid_i), .cfg_bresp_i(cfg_bresp_i), .cfg_bready_o(cfg_bready_o),
    .cfg_arvalid_o(cfg_arvalid_o), .cfg_araddr_o(cfg_araddr_o), .cfg_arready_i(cfg_arready_i),
    .cfg_rvalid_i(cfg_rvalid_i), .cfg_rdata_i(cfg_rdata_i), .cfg_rresp_i(cfg_rresp_i),
    .cfg_rready_o(cfg_rready_o)
  );

  // AR and AW must never be outstanding together
  always @(negedge clk_i) if (cfg_awvalid_o === 1'b1 && cfg_arvalid_o === 1'b1) n_overlap++;

  task automatic idle_inputs();
    req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    cfg_awready_i = 0; cfg_wready_i = 0; cfg_bvalid_i = 0; cfg_bresp_i = 2'b00;
    cfg_arready_i = 0; cfg_rvalid_i = 0; cfg_rdata_i = '0; cfg_rresp_i = 2'b00;
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    rst_i = 1; idle_inputs();
    repeat (3) @(negedge clk_i);
    ctl = {cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, cfg_arvalid_o, cfg_rready_o,
           resp_valid_o, req_ready_o, 1'b0};
    n_checks++;
    if (ctl !== 8'b0000_0010) begin n_fail++; $display("FAIL reset_ctl got %b exp 00000010", ctl); end
    n_checks++;
    if ({cfg_awaddr_o, cfg_araddr_o, cfg_wdata_o, resp_rdata_o} !== 128'h0 || cfg_wstrb_o !== 4'h0 || resp_code_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_data got awaddr %h wdata %h rdata %h code %b exp zero", cfg_awaddr_o, cfg_wdata_o, resp_rdata_o, resp_code_o);
    end
    rst_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_write_basic();
    req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h0000_0008; req_wdata_i = 32'h0000_000F; req_wstrb_i = 4'hF;
    cfg_awready_i = 1; cfg_wready_i = 1;
    @(negedge clk_i);
    n_checks++;
    if ({cfg_awvalid_o, cfg_wvalid_o, req_ready_o} !== 3'b110) begin
      n_fail++; $display("FAIL wr_aw_w_together got aw %b w %b rdy %b exp 1 1 0", cfg_awvalid_o, cfg_wvalid_o, req_ready_o);
    end
    n_checks++;
    if (cfg_awaddr_o !== 32'h8 || cfg_wdata_o !== 32'hF || cfg_wstrb_o !== 4'hF) begin
      n_fail++; $display("FAIL wr_payload got %h %h %h exp 8 f f", cfg_awaddr_o, cfg_wdata_o, cfg_wstrb_o);
    end
    req_valid_i = 0;
    @(negedge clk_i);
    n_checks++;
    if ({cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, resp_valid_o} !== 4'b0010) begin
      n_fail++; $display("FAIL wr_bready got aw %b w %b b %b resp %b exp 0 0 1 0", cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, resp_valid_o);
    end
    cfg_bvalid_i = 1; cfg_bresp_i = 2'b00;
    @(negedge clk_i);
    n_checks++;
    if ({resp_valid_o, cfg_bready_o, req_ready_o} !== 3'b101 || resp_code_o !== 2'b00 || resp_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL wr_resp_latency got v %b bready %b code %b rdata %h exp v=1 bready=0 code=00 rdata=0", resp_valid_o, cfg_bready_o, resp_code_o, resp_rdata_o);
    end
    cfg_bvalid_i = 0; cfg_awready_i = 0; cfg_wready_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr_resp_one_cycle got %b exp 0", resp_valid_o); end
  endtask

  task automatic test_read_wait();
    req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h0000_0010; cfg_arready_i = 1;
    @(negedge clk_i);
    n_checks++;
    if ({cfg_arvalid_o, cfg_awvalid_o} !== 2'b10 || cfg_araddr_o !== 32'h10) begin
      n_fail++; $display("FAIL rd_arvalid got ar %b aw %b addr %h exp 1 0 10", cfg_arvalid_o, cfg_awvalid_o, cfg_araddr_o);
    end
    req_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({cfg_rready_o, cfg_arvalid_o, resp_valid_o} !== 3'b100) begin
        n_fail++; $display("FAIL rd_wait%0d got rready %b ar %b resp %b exp 1 0 0", i, cfg_rready_o, cfg_arvalid_o, resp_valid_o);
      end
    end
    cfg_arready_i = 0;
    cfg_rvalid_i = 1; cfg_rdata_i = 32'h0000_0002; cfg_rresp_i = 2'b00;
    @(negedge clk_i);
    n_checks++;
    if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h2 || resp_code_o !== 2'b00 || cfg_rready_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_resp got v %b rdata %h code %b rready %b exp 1 2 00 0", resp_valid_o, resp_rdata_o, resp_code_o, cfg_rready_o);
    end
    cfg_rvalid_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_w_before_aw();
    int pulses;
    req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h20; req_wdata_i = 32'hA5A5_0001; req_wstrb_i = 4'h3;
    cfg_awready_i = 0; cfg_wready_i = 1;
    @(negedge clk_i);
    req_valid_i = 0;
    @(negedge clk_i);
    n_checks++;
    if ({cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o} !== 3'b100) begin
      n_fail++; $display("FAIL wfirst_w_dropped got aw %b w %b b %b exp 1 0 0", cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o);
    end
    cfg_wready_i = 0;
    @(negedge clk_i);
    n_checks++;
    if ({cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o} !== 3'b100) begin
      n_fail++; $display("FAIL wfirst_aw_held got aw %b w %b b %b exp 1 0 0", cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o);
    end
    cfg_awready_i = 1;
    @(negedge clk_i);
    n_checks++;
    if ({cfg_awvalid_o, cfg_bready_o} !== 2'b01) begin
      n_fail++; $display("FAIL wfirst_to_bresp got aw %b b %b exp 0 1", cfg_awvalid_o, cfg_bready_o);
    end
    cfg_awready_i = 0; cfg_bvalid_i = 1; cfg_bresp_i = 2'b00;
    @(negedge clk_i);
    pulses = (resp_valid_o === 1'b1) ? 1 : 0;
    cfg_bvalid_i = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (resp_valid_o === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL wfirst_one_resp got %0d pulses exp 1", pulses); end
  endtask

  task automatic test_back_to_back();
    req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h30; req_wdata_i = 32'h11; req_wstrb_i = 4'hF;
    cfg_awready_i = 1; cfg_wready_i = 1; cfg_arready_i = 1;
    @(negedge clk_i);
    req_we_i = 0; req_addr_i = 32'h34;
    @(negedge clk_i);
    cfg_bvalid_i = 1; cfg_bresp_i = 2'b00;
    @(negedge clk_i);
    n_checks++;
    if ({resp_valid_o, req_ready_o, cfg_arvalid_o} !== 3'b110) begin
      n_fail++; $display("FAIL b2b_ready_on_resp got v %b rdy %b ar %b exp 1 1 0", resp_valid_o, req_ready_o, cfg_arvalid_o);
    end
    cfg_bvalid_i = 0;
    @(negedge clk_i);
    n_checks++;
    if ({cfg_arvalid_o, cfg_awvalid_o, resp_valid_o} !== 3'b100 || cfg_araddr_o !== 32'h34) begin
      n_fail++; $display("FAIL b2b_read_accepted got ar %b aw %b v %b addr %h exp 1 0 0 34", cfg_arvalid_o, cfg_awvalid_o, resp_valid_o, cfg_araddr_o);
    end
    req_valid_i = 0;
    @(negedge clk_i);
    cfg_rvalid_i = 1; cfg_rdata_i = 32'hCAFE_0001; cfg_rresp_i = 2'b01;
    @(negedge clk_i);
    n_checks++;
    if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hCAFE_0001 || resp_code_o !== 2'b01) begin
      n_fail++; $display("FAIL b2b_read_resp got v %b rdata %h code %b exp 1 cafe0001 01", resp_valid_o, resp_rdata_o, resp_code_o);
    end
    cfg_rvalid_i = 0; cfg_awready_i = 0; cfg_wready_i = 0; cfg_arready_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (n_overlap !== 0) begin n_fail++; $display("FAIL b2b_no_overlap got %0d overlap cycles exp 0", n_overlap); end
  endtask

  task automatic test_bresp_err_and_reset();
    logic [6:0] ctl;
    req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h40; req_wdata_i = 32'h5; req_wstrb_i = 4'h1;
    cfg_awready_i = 1; cfg_wready_i = 1;
    @(negedge clk_i);
    req_valid_i = 0;
    @(negedge clk_i);
    cfg_bvalid_i = 1; cfg_bresp_i = 2'b10;
    @(negedge clk_i);
    n_checks++;
    if (resp_valid_o !== 1'b1 || resp_code_o !== 2'b10 || resp_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL bresp_slverr got v %b code %b rdata %h exp 1 10 0", resp_valid_o, resp_code_o, resp_rdata_o);
    end
    cfg_bvalid_i = 0; cfg_awready_i = 0; cfg_wready_i = 0;
    // read into RD_RESP, then reset while R is arriving
    req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h44; cfg_arready_i = 1;
    @(negedge clk_i);
    req_valid_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (cfg_rready_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rready got %b exp 1", cfg_rready_o); end
    rst_i = 1; cfg_rvalid_i = 1; cfg_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    ctl = {cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, cfg_arvalid_o, cfg_rready_o, resp_valid_o, req_ready_o};
    n_checks++;
    if (ctl !== 7'b000_0001 || resp_rdata_o !== 32'h0 || resp_code_o !== 2'b00 || cfg_araddr_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_rd got ctl %b rdata %h code %b addr %h exp 0000001 0 00 0", ctl, resp_rdata_o, resp_code_o, cfg_araddr_o);
    end
    rst_i = 0; cfg_rvalid_i = 0; cfg_arready_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (resp_valid_o !== 1'b0 || cfg_rready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_resp got v %b rready %b exp 0 0", resp_valid_o, cfg_rready_o);
    end
  endtask

`ifdef CFG_AXIL_TIMEOUT_EN
  task automatic test_timeout();
    int held;
    req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h50; cfg_arready_i = 0;
    @(negedge clk_i);
    req_valid_i = 0;
    held = 0;
    for (int i = 0; i < 16; i++) begin
      if (cfg_arvalid_o === 1'b1 && resp_valid_o === 1'b0) held++;
      @(negedge clk_i);
    end
    n_checks++;
    if (held !== 16) begin n_fail++; $display("FAIL tmo_arvalid_held got %0d cycles exp 16", held); end
    n_checks++;
    if (cfg_arvalid_o !== 1'b0 || resp_valid_o !== 1'b1 || resp_code_o !== 2'b11 || resp_rdata_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL tmo_resp got ar %b v %b code %b rdata %h exp 0 1 11 deadbeef", cfg_arvalid_o, resp_valid_o, resp_code_o, resp_rdata_o);
    end
    @(negedge clk_i);
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_w_before_aw();
    test_back_to_back();
    test_bresp_err_and_reset();
`ifdef CFG_AXIL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
